// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC producing cos/sin of a
// Q4.23 angle. The angle is clamped to [-pi/2, +pi/2] when it is accepted,
// and one micro-rotation is performed per clock.
//
// Handshake: start is sampled on every rising edge but acts only in IDLE.
// busy is high in RUN and DONE, and any start seen while busy is dropped,
// with no queueing. done is high for exactly the one DONE cycle. cos_out
// and sin_out take their new values on the edge that enters DONE, so they
// are already valid while done is high, and they hold until the next DONE.
module cordic_rotator #(
    parameter int ITERATIONS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [26:0] angle_in,
    output logic        busy,
    output logic        done,
    output logic [26:0] cos_out,
    output logic [26:0] sin_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // K = prod 1/sqrt(1+2^-2i) pre-applied, so the final x/y need no scaling.
    localparam logic signed [26:0] K_INIT  = 27'sd5094007;
    localparam logic signed [26:0] ANG_MAX = 27'sd13176795;
    localparam logic signed [26:0] ANG_MIN = -27'sd13176795;
    localparam logic [4:0]         LAST_I  = 5'(ITERATIONS - 1);

    state_t            state;
    state_t            state_next;
    logic signed [26:0] x;
    logic signed [26:0] y;
    logic signed [26:0] z;
    logic [4:0]         i;

    logic signed [26:0] angle_s;
    logic signed [26:0] z_load;
    logic signed [26:0] x_shift;
    logic signed [26:0] y_shift;
    logic signed [26:0] atan_i;
    logic signed [26:0] x_next;
    logic signed [26:0] y_next;
    logic signed [26:0] z_next;
    logic               last_iter;

    // round(atan(2^-i) * 2^23); entries beyond 23 are never reached.
    function automatic logic signed [26:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 27'sd6588397;
            5'd1:    atan_lut = 27'sd3889358;
            5'd2:    atan_lut = 27'sd2055030;
            5'd3:    atan_lut = 27'sd1043165;
            5'd4:    atan_lut = 27'sd523607;
            5'd5:    atan_lut = 27'sd262059;
            5'd6:    atan_lut = 27'sd131061;
            5'd7:    atan_lut = 27'sd65535;
            5'd8:    atan_lut = 27'sd32768;
            5'd9:    atan_lut = 27'sd16384;
            5'd10:   atan_lut = 27'sd8192;
            5'd11:   atan_lut = 27'sd4096;
            5'd12:   atan_lut = 27'sd2048;
            5'd13:   atan_lut = 27'sd1024;
            5'd14:   atan_lut = 27'sd512;
            5'd15:   atan_lut = 27'sd256;
            5'd16:   atan_lut = 27'sd128;
            5'd17:   atan_lut = 27'sd64;
            5'd18:   atan_lut = 27'sd32;
            5'd19:   atan_lut = 27'sd16;
            5'd20:   atan_lut = 27'sd8;
            5'd21:   atan_lut = 27'sd4;
            5'd22:   atan_lut = 27'sd2;
            5'd23:   atan_lut = 27'sd1;
            default: atan_lut = 27'sd0;
        endcase
    endfunction

    // Clamp the incoming angle into the range where CORDIC converges.
    always_comb begin
        angle_s = $signed(angle_in);
        z_load  = angle_s;
        if (angle_s > ANG_MAX) begin
            z_load = ANG_MAX;
        end else if (angle_s < ANG_MIN) begin
            z_load = ANG_MIN;
        end
    end

    // One micro-rotation, steered by the sign of the residual angle.
    always_comb begin
        x_shift   = x >>> i;
        y_shift   = y >>> i;
        atan_i    = atan_lut(i);
        last_iter = (i == LAST_I);
        if (!z[26]) begin
            x_next = x - y_shift;
            y_next = y + x_shift;
            z_next = z - atan_i;
        end else begin
            x_next = x + y_shift;
            y_next = y - x_shift;
            z_next = z + atan_i;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: load on accept, iterate in RUN, publish the final rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            i       <= '0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x <= K_INIT;
                        y <= '0;
                        z <= z_load;
                        i <= '0;
                    end
                end
                RUN: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    i <= i + 5'd1;
                    if (last_iter) begin
                        cos_out <= x_next;
                        sin_out <= y_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
